// File: rtl/snake_frame_render.sv
// Paints the snake / splash cell list into a double-buffered colour RAM.
// The serialiser reads the front buffer through a registered read port while the back buffer is painted.
module snake_frame_render #(
    parameter int                 GRID_N     = 64,
    parameter int                 IDX_W      = 6,
    parameter int                 MAX_LEN    = 8,
    parameter int                 LEN_W      = 4,
    parameter int                 COLOR_W    = 24,
    parameter logic [COLOR_W-1:0] BG_COLOR   = 24'h000000,
    parameter logic [COLOR_W-1:0] BODY_COLOR = 24'h110000,
    parameter logic [COLOR_W-1:0] HEAD_COLOR = 24'h111100,
    parameter logic [COLOR_W-1:0] FOOD_COLOR = 24'h001100
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     frame_start,
    input  logic                     snake_en,
    input  logic [MAX_LEN*IDX_W-1:0] body_pos,
    input  logic [LEN_W-1:0]         body_len,
    input  logic [MAX_LEN*IDX_W-1:0] start_pos,
    input  logic [IDX_W-1:0]         food_pos,
    input  logic                     food_en,
    output logic                     busy,
    output logic                     frame_done,
    input  logic                     rd_en,
    input  logic [IDX_W-1:0]         rd_addr,
    output logic [COLOR_W-1:0]       rd_color,
    output logic                     rd_valid
);

    typedef enum logic [2:0] {IDLE, CLEAR, BODY, HEAD, FOOD, DONE} state_t;

    localparam int               RAM_DEPTH = 2 ** (IDX_W + 1);
    localparam int               SEG_SLOTS = 2 ** LEN_W;
    localparam logic [IDX_W:0]   GRID_LIM  = (IDX_W + 1)'(GRID_N);
    localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(GRID_N - 1);
    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    state_t                   state_reg;
    logic [IDX_W-1:0]         cell_cnt_reg;
    logic [LEN_W-1:0]         seg_idx_reg;
    logic [LEN_W-1:0]         len_reg;
    logic                     snake_en_reg;
    logic                     food_en_reg;
    logic [MAX_LEN*IDX_W-1:0] pos_reg;
    logic [IDX_W-1:0]         food_pos_reg;
    logic                     front_sel_reg;
    logic                     frame_valid_reg;

    logic [LEN_W-1:0]         len_clamped;
    logic [LEN_W-1:0]         seg_last;
    logic [IDX_W-1:0]         pos_arr [SEG_SLOTS];

    logic                     wr_en_next;
    logic [IDX_W-1:0]         wr_cell_next;
    logic [COLOR_W-1:0]       wr_color_next;

    logic [COLOR_W-1:0]       ram [RAM_DEPTH];

    assign len_clamped = (body_len > MAX_L) ? MAX_L : body_len;
    assign seg_last    = snake_en_reg ? ONE_L : '0;

    // Unpack the snapshot list; slots past MAX_LEN exist only so the index width matches the array.
    generate
        for (genvar gi = 0; gi < SEG_SLOTS; gi++) begin : g_unpack
            if (gi < MAX_LEN) begin : g_used
                assign pos_arr[gi] = pos_reg[gi*IDX_W +: IDX_W];
            end else begin : g_pad
                assign pos_arr[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg       <= IDLE;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            cell_cnt_reg    <= '0;
            seg_idx_reg     <= '0;
            len_reg         <= '0;
            snake_en_reg    <= 1'b0;
            food_en_reg     <= 1'b0;
            pos_reg         <= '0;
            food_pos_reg    <= '0;
            front_sel_reg   <= 1'b0;
            frame_valid_reg <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (frame_start) begin
                        snake_en_reg <= snake_en;
                        pos_reg      <= snake_en ? body_pos : start_pos;
                        len_reg      <= len_clamped;
                        food_pos_reg <= food_pos;
                        food_en_reg  <= food_en;
                        cell_cnt_reg <= '0;
                        busy         <= 1'b1;
                        state_reg    <= CLEAR;
                    end
                end
                CLEAR: begin
                    cell_cnt_reg <= cell_cnt_reg + IDX_W'(1);
                    if (cell_cnt_reg == LAST_CELL) begin
                        if (!snake_en_reg) begin
                            seg_idx_reg <= LEN_W'(MAX_LEN - 1);
                            state_reg   <= BODY;
                        end else if (len_reg > ONE_L) begin
                            seg_idx_reg <= len_reg - ONE_L;
                            state_reg   <= BODY;
                        end else begin
                            state_reg <= HEAD;
                        end
                    end
                end
                BODY: begin
                    if (seg_idx_reg == seg_last) begin
                        state_reg <= HEAD;
                    end else begin
                        seg_idx_reg <= seg_idx_reg - ONE_L;
                    end
                end
                HEAD: state_reg <= FOOD;
                FOOD: begin
                    frame_done <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: begin
                    busy            <= 1'b0;
                    front_sel_reg   <= ~front_sel_reg;
                    frame_valid_reg <= 1'b1;
                    state_reg       <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Write order alone gives the overlap priority: later states overwrite earlier ones.
    always_comb begin
        wr_en_next    = 1'b0;
        wr_cell_next  = '0;
        wr_color_next = BG_COLOR;
        case (state_reg)
            CLEAR: begin
                wr_en_next   = 1'b1;
                wr_cell_next = cell_cnt_reg;
            end
            BODY: begin
                wr_en_next    = 1'b1;
                wr_cell_next  = pos_arr[seg_idx_reg];
                wr_color_next = BODY_COLOR;
            end
            HEAD: begin
                wr_en_next    = snake_en_reg && (len_reg != '0);
                wr_cell_next  = pos_arr[0];
                wr_color_next = HEAD_COLOR;
            end
            FOOD: begin
                wr_en_next    = snake_en_reg && food_en_reg;
                wr_cell_next  = food_pos_reg;
                wr_color_next = FOOD_COLOR;
            end
            default: ;
        endcase
        if ({1'b0, wr_cell_next} >= GRID_LIM) begin
            wr_en_next = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en_next) begin
            ram[{~front_sel_reg, wr_cell_next}] <= wr_color_next;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_color <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (!frame_valid_reg || ({1'b0, rd_addr} >= GRID_LIM)) begin
                    rd_color <= BG_COLOR;
                end else begin
                    rd_color <= ram[{front_sel_reg, rd_addr}];
                end
            end
        end
    end

endmodule

// File: doc/snake_frame_render.md
Name: snake_frame_render

Overview:
- Sequential successor to the combinational snake pixel-colour map for the 8x8 WS2812 matrix.
- Snapshots the snake/splash position list and paints it into a double-buffered colour RAM with a scan state machine.
- The serialiser reads pixel colours through a registered read port, so reads never see a half-painted frame.
- Grid size, maximum snake length, colour width and per-object colours are parametrised; the snake has a distinct head colour and a separate food cell.

Parameters:
- GRID_N, 64, number of LED pixels (cells 0..GRID_N-1).
- IDX_W, 6, width of one cell index; 2^IDX_W >= GRID_N.
- MAX_LEN, 8, maximum snake segments / splash cells.
- LEN_W, 4, width of body_len; 2^LEN_W > MAX_LEN.
- COLOR_W, 24, pixel colour width, GRB order.
- BG_COLOR, 24'h000000, background colour.
- BODY_COLOR, 24'h110000, body and splash colour (green).
- HEAD_COLOR, 24'h111100, head colour.
- FOOD_COLOR, 24'h001100, food colour (red).

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle request to render a new frame.
- snake_en  in  1  1 = game mode, 0 = splash mode; sampled with frame_start.
- body_pos  in  MAX_LEN*IDX_W  snake cells; entry j = [j*IDX_W +: IDX_W]; entry 0 is the head.
- body_len  in  LEN_W  valid snake entries.
- start_pos  in  MAX_LEN*IDX_W  splash cells, same packing.
- food_pos  in  IDX_W  food cell.
- food_en  in  1  food present.
- busy  out  1  render in progress.
- frame_done  out  1  one-cycle pulse when the new frame becomes visible.
- rd_en  in  1  read request.
- rd_addr  in  IDX_W  pixel to read.
- rd_color  out  COLOR_W  pixel colour, valid when rd_valid.
- rd_valid  out  1  rd_en delayed by one cycle.

Behaviour:
- Reset (async, sys_rst_n=0):
  - State IDLE; busy=0, frame_done=0, rd_valid=0, rd_color=0.
  - Front-buffer select = 0; frame_valid flag = 0.
  - RAM contents are not reset.
- Snapshot:
  - frame_start is accepted only in IDLE; it is ignored while busy (no queueing).
  - On accept, register snake_en, the selected position list, L = min(body_len, MAX_LEN), food_pos and food_en.
  - Later input changes do not affect the frame in progress.
- FSM states, in order: IDLE -> CLEAR -> BODY -> HEAD -> FOOD -> DONE -> IDLE.
  - CLEAR: GRID_N cycles; writes BG_COLOR to back-buffer cells 0..GRID_N-1, one per cycle.
  - BODY, game mode: B = max(L-1, 0) cycles; writes BODY_COLOR at entries L-1 down to 1.
  - BODY, splash mode: B = MAX_LEN cycles; writes entries MAX_LEN-1 down to 0.
  - HEAD: 1 cycle; writes HEAD_COLOR at entry 0, only in game mode with L >= 1.
  - FOOD: 1 cycle; writes FOOD_COLOR at food_pos, only in game mode with food_en = 1.
  - DONE: 1 cycle; frame_done = 1, front/back buffers swap, frame_valid set to 1.
- Overlap priority follows from write order: food > head > body > background.
  - Duplicate body entries are harmless.
- Any write whose cell index is >= GRID_N is suppressed; the FSM still spends that cycle.
- busy:
  - Goes high the cycle after frame_start is accepted.
  - Stays high through the DONE cycle; low in the cycle after.
  - frame_done occurs exactly GRID_N+B+3 cycles after the frame_start cycle.
- Read port:
  - rd_en is sampled every cycle (including while busy); it always reads the front buffer.
  - rd_color is registered and appears the cycle after rd_en, with rd_valid = 1.
  - Before the first frame_done (frame_valid = 0), or when rd_addr >= GRID_N, rd_color = BG_COLOR.
  - A read sampled in the DONE cycle returns the old front buffer; a read sampled one cycle later returns the new one.
  - When rd_en = 0, rd_color holds its value and rd_valid = 0.
- Reset mid-render: FSM aborts to IDLE, frame_valid clears, no frame_done pulse.
- ges_data direction decode is not part of this block.

Test Plan:
- Reset, then rd_en with rd_addr=5, no frame rendered -> next cycle rd_valid=1, rd_color=24'h000000.
- Game mode, body_pos entries {0:10, 1:11, 2:12, 3:13}, body_len=4, food_en=1, food_pos=40:
  - frame_done exactly 64+3+3=70 cycles after frame_start.
  - Reads return cell 10 = 24'h111100; cells 11, 12, 13 = 24'h110000; cell 40 = 24'h001100; cell 0 = 24'h000000.
- Splash mode, start_pos = cells 0..7, food_en=1:
  - frame_done 64+8+3=75 cycles after frame_start.
  - Cells 0..7 = BODY_COLOR; food cell reads BG.
- Overlap case: food_pos=10 equal to the head cell -> cell 10 reads 24'h001100.
  - body_len=0 -> only the food cell is lit; frame_done at 67 cycles.
- Second frame_start pulsed mid-render -> ignored, exactly one frame_done.
  - Continuous reads of cell 10 during render return the previous frame until the DONE cycle, then the new colour.
- Assert sys_rst_n=0 during BODY -> busy=0 immediately, no frame_done pulse, subsequent reads return BG.
